// File: rtl/scanline_prefetcher_if.sv
// scanline_prefetcher_if: host write port, pixel RAM bus and line buffer write port of the prefetcher
interface scanline_prefetcher_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 24,
    parameter int LB_ADDR_WIDTH = 10
);
    logic host_wr_req;
    logic [ADDR_WIDTH-1:0] host_wr_addr;
    logic [DATA_WIDTH-1:0] host_wr_data;
    logic host_wr_ack;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic mem_re;
    logic mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic lb_we;
    logic lb_bank;
    logic [LB_ADDR_WIDTH-1:0] lb_addr;
    logic [DATA_WIDTH-1:0] lb_data;
    modport master (
        input host_wr_req, host_wr_addr, host_wr_data, mem_rdata,
        output host_wr_ack, mem_addr, mem_re, mem_we, mem_wdata, lb_we, lb_bank, lb_addr, lb_data
    );
    modport slave (
        output host_wr_req, host_wr_addr, host_wr_data, mem_rdata,
        input host_wr_ack, mem_addr, mem_re, mem_we, mem_wdata, lb_we, lb_bank, lb_addr, lb_data
    );
endinterface

// File: rtl/scanline_prefetcher.sv
// scanline_prefetcher: counts video strobes and prefetches each active line into a ping-pong line buffer,
// sharing the single-port pixel RAM with host writes
module scanline_prefetcher #(
    parameter int LINE_PIXELS = 800,
    parameter int LINES = 720,
    parameter int VBLANK_LINES = 10,
    parameter int HOST_SLOT = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 24,
    parameter int LB_ADDR_WIDTH = 10
) (
    input logic pixel_clock,
    input logic reset,
    input logic video_vsync,
    input logic video_hsync,
    scanline_prefetcher_if.master bus,
    output logic fetch_busy,
    output logic underrun
);
    localparam int NW = $clog2(LINES + 1);
    localparam int SW = $clog2(HOST_SLOT);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state_q, state_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic [NW-1:0] n_q, n_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LB_ADDR_WIDTH-1:0] p_q, p_d, rd_p_q;
    logic [SW-1:0] slot_q, slot_d;
    logic rd_v_q, rd_bank_q, underrun_q;
    logic busy, trig, grant, re, gnt_o, re_o, lb_v;
    int tgt;
    always_comb begin
        busy = state_q != IDLE;
        // while a line is still in flight, the next trigger belongs to the following line
        tgt = 32'(n_q) + (busy ? 1 : 0);
        trig = video_hsync && !video_vsync && (32'(hcnt_q) + 1 == VBLANK_LINES + tgt) && tgt < LINES;
        grant = bus.host_wr_req && (state_q != FETCH || 32'(slot_q) >= HOST_SLOT - 1);
        re = state_q == FETCH && !grant && !trig && !video_vsync;
        state_d = state_q;
        hcnt_d = hcnt_q;
        n_d = n_q;
        base_d = base_q;
        p_d = p_q;
        slot_d = slot_q;
        if (video_vsync) begin
            state_d = IDLE;
            hcnt_d = '0;
            n_d = '0;
            base_d = '0;
        end else begin
            hcnt_d = video_hsync && hcnt_q != '1 ? hcnt_q + 1'b1 : hcnt_q;
            if (trig) begin
                base_d = busy ? base_q + ADDR_WIDTH'(LINE_PIXELS) : base_q;
                n_d = busy ? n_q + 1'b1 : n_q;
                state_d = FETCH;
                p_d = '0;
                slot_d = '0;
            end else if (state_q == FETCH) begin
                slot_d = grant ? '0 : 32'(slot_q) < HOST_SLOT - 1 ? slot_q + 1'b1 : slot_q;
                p_d = re ? p_q + 1'b1 : p_q;
                state_d = re && 32'(p_q) == LINE_PIXELS - 1 ? DRAIN : FETCH;
            end else if (state_q == DRAIN) begin
                state_d = IDLE;
                base_d = base_q + ADDR_WIDTH'(LINE_PIXELS);
                n_d = n_q + 1'b1;
            end
        end
    end
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state_q <= IDLE;
            hcnt_q <= '0;
            n_q <= '0;
            base_q <= '0;
            p_q <= '0;
            slot_q <= '0;
            rd_v_q <= 1'b0;
            rd_p_q <= '0;
            rd_bank_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q <= hcnt_d;
            n_q <= n_d;
            base_q <= base_d;
            p_q <= p_d;
            slot_q <= slot_d;
            rd_v_q <= re;
            rd_p_q <= p_q;
            rd_bank_q <= n_q[0];
            underrun_q <= trig && busy;
        end
    end
    // outputs are forced low during reset so a fetch caught mid-flight emits nothing further
    assign gnt_o = !reset && grant;
    assign re_o = !reset && re;
    assign lb_v = !reset && rd_v_q;
    assign bus.host_wr_ack = gnt_o;
    assign bus.mem_we = gnt_o;
    assign bus.mem_re = re_o;
    assign bus.mem_addr = gnt_o ? bus.host_wr_addr : re_o ? base_q + ADDR_WIDTH'(p_q) : '0;
    assign bus.mem_wdata = gnt_o ? bus.host_wr_data : '0;
    assign bus.lb_we = lb_v;
    assign bus.lb_bank = lb_v && rd_bank_q;
    assign bus.lb_addr = lb_v ? rd_p_q : '0;
    assign bus.lb_data = lb_v ? bus.mem_rdata : '0;
    assign fetch_busy = !reset && busy;
    assign underrun = !reset && underrun_q;
endmodule

// File: tb/tb_scanline_prefetcher.sv
// tb_scanline_prefetcher: directed vectors against a small line geometry with a synchronous RAM model
module tb_scanline_prefetcher;
    logic clk, reset, video_vsync, video_hsync, fetch_busy, underrun;
    logic [23:0] ram_q;
    int tests, fails;
    scanline_prefetcher_if #(.ADDR_WIDTH(20), .DATA_WIDTH(24), .LB_ADDR_WIDTH(3)) bus_if ();
    scanline_prefetcher #(
        .LINE_PIXELS(8), .LINES(4), .VBLANK_LINES(2), .HOST_SLOT(4),
        .ADDR_WIDTH(20), .DATA_WIDTH(24), .LB_ADDR_WIDTH(3)
    ) dut (
        .pixel_clock(clk), .reset(reset), .video_vsync(video_vsync), .video_hsync(video_hsync),
        .bus(bus_if), .fetch_busy(fetch_busy), .underrun(underrun)
    );
    function automatic int pix(int a);
        return 32'h00C30000 ^ (a & 32'h000FFFFF);
    endfunction
    always @(posedge clk) if (bus_if.mem_re) ram_q <= 24'(pix(32'(bus_if.mem_addr)));
    assign bus_if.mem_rdata = ram_q;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    typedef struct {
        int vs, hs, re, busy, ma, lbwe, lba;
    } vec_t;
    vec_t tbl[14];
    function automatic vec_t mk(int vs, int hs, int re, int busy, int ma, int lbwe, int lba);
        vec_t v;
        v.vs = vs; v.hs = hs; v.re = re; v.busy = busy; v.ma = ma; v.lbwe = lbwe; v.lba = lba;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic cyc(input int vs, input int hs, input int rq, input int ha, input int hd);
        @(negedge clk);
        video_vsync = 1'(vs);
        video_hsync = 1'(hs);
        bus_if.host_wr_req = 1'(rq);
        bus_if.host_wr_addr = 20'(ha);
        bus_if.host_wr_data = 24'(hd);
        #1;
    endtask
    task automatic exp_out(input string nm, input int re, input int we, input int ack, input int busy, input int ur,
                           input int ma, input int wd, input int lbwe, input int bank, input int lba, input int lbd);
        chk({nm, " mem"},
            64'({bus_if.mem_re, bus_if.mem_we, bus_if.host_wr_ack, fetch_busy, underrun, bus_if.mem_addr, bus_if.mem_wdata}),
            64'({1'(re), 1'(we), 1'(ack), 1'(busy), 1'(ur), 20'(ma), 24'(wd)}));
        chk({nm, " lb"}, 64'({bus_if.lb_we, bus_if.lb_bank, bus_if.lb_addr, bus_if.lb_data}),
            lbwe != 0 ? 64'({1'b1, 1'(bank), 3'(lba), 24'(lbd)}) : 64'(0));
    endtask
    task automatic zero(input string nm);
        exp_out(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic hs_line(input int b, input int bank, input string nm);
        cyc(0, 1, 0, 0, 0);
        zero({nm, " trig"});
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0, 0);
            exp_out($sformatf("%s rd%0d", nm, i), 1, 0, 0, 1, 0, b + i, 0, i > 0 ? 1 : 0, bank, i - 1, pix(b + i - 1));
        end
        cyc(0, 0, 0, 0, 0);
        exp_out({nm, " drain"}, 0, 0, 0, 1, 0, 0, 0, 1, bank, 7, pix(b + 7));
        cyc(0, 0, 0, 0, 0);
        zero({nm, " done"});
    endtask
    initial begin
        int busy_cnt;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        video_vsync = 1'b0;
        video_hsync = 1'b0;
        bus_if.host_wr_req = 1'b0;
        bus_if.host_wr_addr = '0;
        bus_if.host_wr_data = '0;
        tbl[0] = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 1, 0, 0, 0, 0, 0);
        tbl[2] = mk(0, 0, 0, 0, 0, 0, 0);
        tbl[3] = mk(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tbl[4 + i] = mk(0, 0, 1, 1, i, i > 0 ? 1 : 0, i - 1);
        tbl[12] = mk(0, 0, 0, 1, 0, 1, 7);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0);
        // reset with random stimulus
        for (int i = 0; i < 3; i++) begin
            cyc(int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(1)),
                int'($urandom_range(1048575)), int'($urandom_range(16777215)));
            zero($sformatf("rst%0d", i));
        end
        @(negedge clk);
        reset = 1'b0;
        video_vsync = 1'b0;
        video_hsync = 1'b0;
        bus_if.host_wr_req = 1'b0;
        #1;
        zero("post rst");
        cyc(0, 1, 0, 0, 0);
        zero("first hs");
        cyc(0, 0, 0, 0, 0);
        zero("first hs idle");
        // line 0 after vsync, cycle by cycle
        for (int k = 0; k < 14; k++) begin
            cyc(tbl[k].vs, tbl[k].hs, 0, 0, 0);
            exp_out($sformatf("t2[%0d]", k), tbl[k].re, 0, 0, tbl[k].busy, 0, tbl[k].ma, 0,
                    tbl[k].lbwe, 0, tbl[k].lba, pix(tbl[k].lba));
        end
        hs_line(8, 1, "l1");
        hs_line(16, 0, "l2");
        hs_line(24, 1, "l3");
        cyc(0, 1, 0, 0, 0);
        zero("hs5");
        cyc(0, 0, 0, 0, 0);
        zero("hs5 idle");
        cyc(1, 0, 0, 0, 0);
        zero("vs2");
        cyc(0, 1, 0, 0, 0);
        zero("vs2 hs0");
        hs_line(0, 0, "restart");
        // host write held from fetch start
        cyc(1, 0, 0, 0, 0);
        zero("t4 vs");
        cyc(0, 1, 0, 0, 0);
        zero("t4 hs0");
        cyc(0, 1, 0, 0, 0);
        zero("t4 trig");
        busy_cnt = 0;
        for (int f = 1; f <= 10; f++) begin
            int g, isrd, rd, lbwe, lba;
            cyc(0, 0, f <= 4 ? 1 : 0, 100, 32'hABCDEF);
            if (fetch_busy) busy_cnt++;
            g = f == 4 ? 1 : 0;
            isrd = f != 4 && f != 10 ? 1 : 0;
            rd = f < 4 ? f - 1 : f - 2;
            lbwe = (f >= 2 && f <= 4) || f >= 6 ? 1 : 0;
            lba = f <= 4 ? f - 2 : f - 3;
            exp_out($sformatf("t4 f%0d", f), isrd, g, g, 1, 0, g != 0 ? 100 : isrd != 0 ? rd : 0,
                    g != 0 ? 32'hABCDEF : 0, lbwe, 0, lba, pix(lba));
        end
        cyc(0, 0, 0, 0, 0);
        if (fetch_busy) busy_cnt++;
        zero("t4 done");
        chk("t4 busy cycles", 64'(busy_cnt), 64'(10));
        // retrigger mid-line, then vsync mid-line
        cyc(1, 0, 0, 0, 0);
        zero("t5 vs");
        cyc(0, 1, 0, 0, 0);
        zero("t5 hs0");
        cyc(0, 1, 0, 0, 0);
        zero("t5 trig");
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0);
            exp_out($sformatf("t5 rd%0d", i), 1, 0, 0, 1, 0, i, 0, i > 0 ? 1 : 0, 0, i - 1, pix(i - 1));
        end
        cyc(0, 1, 0, 0, 0);
        exp_out("t5 retrig", 0, 0, 0, 1, 0, 0, 0, 1, 0, 4, pix(4));
        cyc(0, 0, 0, 0, 0);
        exp_out("t5 underrun", 1, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        exp_out("t5 l1 rd1", 1, 0, 0, 1, 0, 9, 0, 1, 1, 0, pix(8));
        cyc(0, 0, 0, 0, 0);
        exp_out("t5 l1 rd2", 1, 0, 0, 1, 0, 10, 0, 1, 1, 1, pix(9));
        cyc(1, 0, 0, 0, 0);
        exp_out("t5 vs abort", 0, 0, 0, 1, 0, 0, 0, 1, 1, 2, pix(10));
        cyc(0, 0, 0, 0, 0);
        zero("t5 aborted");
        cyc(0, 0, 0, 0, 0);
        zero("t5 idle");
        // host writes while idle
        cyc(0, 0, 1, 5, 32'h123456);
        exp_out("t6 single", 0, 1, 1, 0, 0, 5, 32'h123456, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 200 + i, 32'h111111 * (i + 1));
            exp_out($sformatf("t6 burst%0d", i), 0, 1, 1, 0, 0, 200 + i, 32'h111111 * (i + 1), 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        zero("t6 done");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
